// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer: state encodings, default
// geometry and the scan mode constants.
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  localparam int DIV_DEFAULT  = 4;
  localparam int LAST_DEFAULT = 7;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

endpackage

// File: rtl/scan_prescaler.sv
// Dwell counter for one select slot: counts while enabled, wraps at DIV-1
// and flags that last cycle with tc; clear has priority over counting.
module scan_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(DIV - 1);

  logic [7:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, and the async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == TC_VAL) ? '0 : cnt + 8'd1;
    end
  end

  assign tc = en && (cnt == TC_VAL);

endmodule

// File: rtl/scan_sequencer.sv
// Scans a 3-to-8 active-low decoder through slots 0..LAST, DIV cycles each.
// Define SCAN_BLANK_EN to insert one blanking cycle after every slot.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int DIV  = DIV_DEFAULT,
  parameter int LAST = LAST_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  output logic       enb_,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_SEL = 3'(LAST);

  scan_state_e state;
  logic        mode_q;
  logic        tc;
  logic        end_of_slot;
  logic        last_slot;
  logic [2:0]  next_sel;

  scan_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst_  (rst_),
    .clear (state != ST_DRIVE),
    .en    (state == ST_DRIVE),
    .tc    (tc)
  );

`ifdef SCAN_BLANK_EN
  assign end_of_slot = (state == ST_BLANK);
`else
  assign end_of_slot = (state == ST_DRIVE) && tc;
`endif

  assign last_slot = (sel == LAST_SEL);
  assign next_sel  = last_slot ? 3'd0 : sel + 3'd1;

  // enb_ is computed from the select value the next cycle will present, so
  // the decoder never sees a stale enable while sel moves.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state  <= ST_IDLE;
      sel    <= 3'd0;
      enb_   <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      mode_q <= MODE_CONT;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && stop) begin
        state <= ST_IDLE;
        sel   <= 3'd0;
        enb_  <= 1'b1;
        busy  <= 1'b0;
      end else if (end_of_slot) begin
        if (!last_slot || mode_q == MODE_CONT) begin
          state <= ST_DRIVE;
          sel   <= next_sel;
          enb_  <= ~mask[next_sel];
        end else begin
          state <= ST_IDLE;
          sel   <= 3'd0;
          enb_  <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !stop) begin
              state  <= ST_DRIVE;
              sel    <= 3'd0;
              enb_   <= ~mask[0];
              busy   <= 1'b1;
              mode_q <= mode;
            end
          end
          ST_DRIVE: begin
`ifdef SCAN_BLANK_EN
            if (tc) begin
              state <= ST_BLANK;
              enb_  <= 1'b1;
            end else begin
              enb_ <= ~mask[sel];
            end
`else
            enb_ <= ~mask[sel];
`endif
          end
          default: begin
            state <= ST_IDLE;
            sel   <= 3'd0;
            enb_  <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: three instances with different DIV/LAST
// share stimulus; each scenario checks the instance it targets cycle by cycle.
module tb_scan_sequencer;

`ifdef SCAN_BLANK_EN
  localparam int BL = 1;
`else
  localparam int BL = 0;
`endif
  localparam int DIV_A = 2, DIV_B = 1, DIV_C = 3;
  localparam int SL_A = DIV_A + BL, SL_B = DIV_B + BL, SL_C = DIV_C + BL;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       start = 1'b0, stop = 1'b0, mode = 1'b0;
  logic [7:0] mask = 8'hFF;

  logic [2:0] sel_a, sel_b, sel_c;
  logic       enb_a, enb_b, enb_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DIV(DIV_A), .LAST(7)) u_a (
    .clk(clk), .rst_(rst_), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .sel(sel_a), .enb_(enb_a), .busy(busy_a), .done(done_a));

  scan_sequencer #(.DIV(DIV_B), .LAST(3)) u_b (
    .clk(clk), .rst_(rst_), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .sel(sel_b), .enb_(enb_b), .busy(busy_b), .done(done_b));

  scan_sequencer #(.DIV(DIV_C), .LAST(7)) u_c (
    .clk(clk), .rst_(rst_), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .sel(sel_c), .enb_(enb_c), .busy(busy_c), .done(done_c));

  // Outputs are compared as {sel, enb_, busy, done}.
  function automatic logic [5:0] pack(input int s, input logic e, input logic b, input logic d);
    return {3'(s), e, b, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; stop = 1'b0; mode = 1'b0; mask = 8'hFF;
    rst_ = 1'b0;
    tick();
    tick();
    rst_ = 1'b1;
    tick();
  endtask

  // Drives start for one edge; returns in cycle 1 of the scan.
  task automatic kick(input logic m);
    mode = m; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] want;
    want = pack(0, 1'b1, 1'b0, 1'b0);
    #1 rst_ = 1'b0;
    #2;
    tests++;
    if ({sel_a, enb_a, busy_a, done_a} !== want) begin
      fails++; $display("FAIL reset_a got %b want %b", {sel_a, enb_a, busy_a, done_a}, want);
    end
    tests++;
    if ({sel_b, enb_b, busy_b, done_b} !== want) begin
      fails++; $display("FAIL reset_b got %b want %b", {sel_b, enb_b, busy_b, done_b}, want);
    end
    tests++;
    if ({sel_c, enb_c, busy_c, done_c} !== want) begin
      fails++; $display("FAIL reset_c got %b want %b", {sel_c, enb_c, busy_c, done_c}, want);
    end
    start = 1'b1; mode = 1'b1;
    tick();
    tick();
    tests++;
    if ({sel_a, enb_a, busy_a, done_a} !== want) begin
      fails++; $display("FAIL reset_hold got %b want %b", {sel_a, enb_a, busy_a, done_a}, want);
    end
    start = 1'b0;
    rst_ = 1'b1;
    tick();
  endtask

  task automatic test_single_pass();
    logic [5:0] want;
    do_reset();
    kick(1'b1);
    for (int c = 1; c <= 8 * SL_A; c++) begin
      want = pack((c - 1) / SL_A, ((c - 1) % SL_A) >= DIV_A, 1'b1, 1'b0);
      tests++;
      if ({sel_a, enb_a, busy_a, done_a} !== want) begin
        fails++; $display("FAIL single_pass c=%0d got %b want %b", c, {sel_a, enb_a, busy_a, done_a}, want);
      end
      tick();
    end
    want = pack(0, 1'b1, 1'b0, 1'b1);
    tests++;
    if ({sel_a, enb_a, busy_a, done_a} !== want) begin
      fails++; $display("FAIL single_done got %b want %b", {sel_a, enb_a, busy_a, done_a}, want);
    end
    tick();
    want = pack(0, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({sel_a, enb_a, busy_a, done_a} !== want) begin
      fails++; $display("FAIL single_after got %b want %b", {sel_a, enb_a, busy_a, done_a}, want);
    end
  endtask

  task automatic test_continuous();
    logic [5:0] want;
    do_reset();
    kick(1'b0);
    for (int c = 1; c <= 20 * SL_B; c++) begin
      want = pack(((c - 1) / SL_B) % 4, ((c - 1) % SL_B) >= DIV_B, 1'b1, 1'b0);
      tests++;
      if ({sel_b, enb_b, busy_b, done_b} !== want) begin
        fails++; $display("FAIL continuous c=%0d got %b want %b", c, {sel_b, enb_b, busy_b, done_b}, want);
      end
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    want = pack(0, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({sel_b, enb_b, busy_b, done_b} !== want) begin
      fails++; $display("FAIL continuous_stop got %b want %b", {sel_b, enb_b, busy_b, done_b}, want);
    end
  endtask

  task automatic test_mask();
    logic [5:0] want;
    int slot;
    do_reset();
    mask = 8'b1111_1011;
    kick(1'b1);
    for (int c = 1; c <= 8 * SL_C; c++) begin
      slot = (c - 1) / SL_C;
      want = pack(slot, (slot == 2) || (((c - 1) % SL_C) >= DIV_C), 1'b1, 1'b0);
      tests++;
      if ({sel_c, enb_c, busy_c, done_c} !== want) begin
        fails++; $display("FAIL mask c=%0d got %b want %b", c, {sel_c, enb_c, busy_c, done_c}, want);
      end
      tick();
    end
    want = pack(0, 1'b1, 1'b0, 1'b1);
    tests++;
    if ({sel_c, enb_c, busy_c, done_c} !== want) begin
      fails++; $display("FAIL mask_done got %b want %b", {sel_c, enb_c, busy_c, done_c}, want);
    end
  endtask

  task automatic test_stop();
    logic [5:0] want;
    do_reset();
    kick(1'b1);
    for (int c = 1; c <= 5 * SL_A + 2; c++) begin
      start = (c == 3);
      want = pack((c - 1) / SL_A, ((c - 1) % SL_A) >= DIV_A, 1'b1, 1'b0);
      tests++;
      if ({sel_a, enb_a, busy_a, done_a} !== want) begin
        fails++; $display("FAIL stop_run c=%0d got %b want %b", c, {sel_a, enb_a, busy_a, done_a}, want);
      end
      if (c != 5 * SL_A + 2) tick();
    end
    start = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    want = pack(0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({sel_a, enb_a, busy_a, done_a} !== want) begin
        fails++; $display("FAIL stop_idle k=%0d got %b want %b", k, {sel_a, enb_a, busy_a, done_a}, want);
      end
      tick();
    end
  endtask

  task automatic test_start_stop_together();
    logic [5:0] want;
    do_reset();
    mode = 1'b1; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    want = pack(0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({sel_a, enb_a, busy_a, done_a} !== want) begin
        fails++; $display("FAIL start_stop k=%0d got %b want %b", k, {sel_a, enb_a, busy_a, done_a}, want);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] want;
    do_reset();
    kick(1'b1);
    for (int c = 1; c < 4 * SL_A + 1; c++) tick();
    want = pack(4, 1'b0, 1'b1, 1'b0);
    tests++;
    if ({sel_a, enb_a, busy_a, done_a} !== want) begin
      fails++; $display("FAIL reset_mid_pre got %b want %b", {sel_a, enb_a, busy_a, done_a}, want);
    end
    #3 rst_ = 1'b0;
    #1;
    want = pack(0, 1'b1, 1'b0, 1'b0);
    tests++;
    if ({sel_a, enb_a, busy_a, done_a} !== want) begin
      fails++; $display("FAIL reset_mid_async got %b want %b", {sel_a, enb_a, busy_a, done_a}, want);
    end
    #2 rst_ = 1'b1;
    for (int k = 0; k < 4 * SL_A; k++) begin
      tick();
      tests++;
      if ({sel_a, enb_a, busy_a, done_a} !== want) begin
        fails++; $display("FAIL reset_mid_idle k=%0d got %b want %b", k, {sel_a, enb_a, busy_a, done_a}, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_continuous();
    test_mask();
    test_stop();
    test_start_stop_together();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter DIV, default 4, dwell in clock cycles per select slot, legal range 1..255.
REQ-002 SHALL have parameter LAST, default 7, highest select value scanned, legal range 0..7.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin scan; honoured only when idle.
REQ-006 SHALL have port stop  input  1  abort scan.
REQ-007 SHALL have port mode  input  1  0 = continuous, 1 = single pass; sampled with start.
REQ-008 SHALL have port mask  input  8  per-slot drive enable, active-high; sampled live every cycle.
REQ-009 SHALL have port sel  output  3  select code to the downstream 3-to-8 active-low decoder.
REQ-010 SHALL have port enb_  output  1  active-low enable to the downstream decoder.
REQ-011 SHALL have port busy  output  1  high while a scan is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at the end of a single pass.

Function
REQ-013 SHALL register all outputs, with no combinational path from any input to any output.
REQ-014 SHALL implement states IDLE, DRIVE and BLANK (BLANK only per REQ-026).
REQ-015 IDLE SHALL hold sel=0, enb_=1 and busy=0.
REQ-016 start=1 and stop=0 sampled in IDLE SHALL enter DRIVE next cycle with sel=0, busy=1 and the dwell counter cleared, and SHALL latch mode.
REQ-017 DRIVE SHALL last exactly DIV cycles per slot, with enb_ = ~mask[sel] on each of those cycles.
REQ-018 At the end of a slot with sel<LAST, sel SHALL increment by 1 and DRIVE SHALL restart.
REQ-019 At the end of slot LAST in continuous mode, sel SHALL wrap to 0 with no gap cycle.
REQ-020 At the end of slot LAST in single-pass mode, the block SHALL enter IDLE, with done=1 for exactly the first IDLE cycle.
REQ-021 stop=1 sampled in any non-IDLE state SHALL force IDLE next cycle (enb_=1, sel=0, busy=0, done=0).
REQ-022 start while busy SHALL be ignored; start and stop together in IDLE SHALL leave the block in IDLE (stop wins).
REQ-023 enb_ SHALL never be low in the cycle sel changes value unless mask permits and the slot is DRIVE.

Reset
REQ-024 rst_ low SHALL immediately force IDLE, sel=0, enb_=1, busy=0, done=0, dwell counter=0 and latched mode=0.
REQ-025 Reset asserted mid-scan SHALL abort without a done pulse; after release, the block SHALL wait for a new start.

Configuration
REQ-026 With macro SCAN_BLANK_EN defined, each slot's DRIVE SHALL be followed by one BLANK cycle (enb_=1, sel held) before sel advances, wraps or the block goes idle.
REQ-027 Without SCAN_BLANK_EN, the BLANK state and its logic SHALL be absent, and slots SHALL follow back-to-back per REQ-018/019.

Structure
REQ-028 State encodings (IDLE/DRIVE/BLANK), the default DIV and LAST values, and the mode constants SHALL live in shared package scan_pkg.
REQ-029 The dwell counter SHALL be a sub-module scan_prescaler (load/clear, terminal-count pulse at DIV-1).
REQ-030 The block SHALL drive the decoder directly: sel to sel, enb_ to enb_.

Verification
REQ-031 DIV=2, LAST=7, mask=8'hFF, mode=1, no blank, start at cycle 0 -> enb_ low cycles 1..16, sel=0..7 two cycles each, done=1 at cycle 17 only.
REQ-032 Same as REQ-031 with SCAN_BLANK_EN defined -> 24 active cycles, enb_ high every third cycle with sel held, done at cycle 25.
REQ-033 mode=0, DIV=1, LAST=3, mask=8'hFF -> sel sequence 0,1,2,3,0,1,... with enb_ continuously low; done never asserts.
REQ-034 mask=8'b1111_1011, DIV=3 -> enb_=1 for the three cycles of sel=2, low in all other slots.
REQ-035 stop at sel=5 mid-dwell -> next cycle sel=0, enb_=1, busy=0, done=0; start pulsed during the scan has no effect.
REQ-036 rst_ pulsed low asynchronously mid-cycle at sel=4 -> outputs reach reset values before the next edge; no done pulse.
